// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NREQ requesters and routes each result back to the owner,
// with response backpressure. Define ALU_ARB_RR_EN for round-robin instead of fixed priority.
module alu_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [4*NREQ-1:0]  req_ctrl,
   input  logic [16*NREQ-1:0] req_a,
   input  logic [16*NREQ-1:0] req_b,
   output logic [NREQ-1:0]    rsp_valid,
   input  logic [NREQ-1:0]    rsp_ready,
   output logic [15:0]        rsp_data,
   output logic [3:0]         alu_ctrl,
   output logic [15:0]        alu_a,
   output logic [15:0]        alu_b,
   input  logic [15:0]        alu_y,
   output logic               busy
);

   typedef enum logic [1:0] {StIdle = 2'd0, StIssued = 2'd1, StHold = 2'd2} state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   w_owner_nxt;
   logic [15:0]     r_hold;
   logic [15:0]     w_hold_nxt;

   logic            w_pending;
   logic            w_own_rdy;
   logic            w_issue_ok;
   logic            w_found;
   logic            w_issue;
   logic [IW-1:0]   w_gnt_idx;
   logic [IW-1:0]   w_idx;

`ifdef ALU_ARB_RR_EN
   logic [IW-1:0]   r_rr;
   int unsigned     w_rr_sum;
`endif

   assign w_pending  = resetn & (r_state != StIdle);
   assign w_own_rdy  = rsp_ready[r_owner];
   // A new op may issue whenever the result slot is free or is being drained this cycle.
   assign w_issue_ok = resetn & ((r_state == StIdle) | w_own_rdy);

   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_idx     = '0;
`ifdef ALU_ARB_RR_EN
      w_rr_sum  = 0;
`endif
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_RR_EN
         w_rr_sum = (32'(r_rr) + k + 1) % NREQ;
         w_idx    = IW'(w_rr_sum);
`else
         w_idx    = IW'(k);
`endif
         if (!w_found && req_valid[w_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx;
         end
      end
   end

   assign w_issue   = w_issue_ok & w_found;
   assign req_ready = w_issue ? (NREQ'(1) << w_gnt_idx) : '0;
   assign alu_ctrl  = w_issue ? req_ctrl[{w_gnt_idx, 2'b00} +: 4] : '0;
   assign alu_a     = w_issue ? req_a[{w_gnt_idx, 4'b0000} +: 16] : '0;
   assign alu_b     = w_issue ? req_b[{w_gnt_idx, 4'b0000} +: 16] : '0;

   assign rsp_valid = w_pending ? (NREQ'(1) << r_owner) : '0;
   assign busy      = w_pending;

   always_comb begin
      rsp_data = 16'h0;
      if (resetn) begin
         unique case (r_state)
            StIssued: rsp_data = alu_y;
            StHold:   rsp_data = r_hold;
            default:  rsp_data = 16'h0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold;
      if (w_issue) begin
         w_state_nxt = StIssued;
         w_owner_nxt = w_gnt_idx;
      end else begin
         unique case (r_state)
            StIssued: begin
               if (w_own_rdy) begin
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt = StHold;
                  w_hold_nxt  = alu_y;
               end
            end
            StHold: begin
               if (w_own_rdy) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
         r_owner <= '0;
         r_hold  <= 16'h0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rr <= IW'(NREQ - 1);
      end else if (w_issue) begin
         r_rr <= w_gnt_idx;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model and a response scoreboard.
module tb_alu_arbiter;

   localparam int NREQ = 4;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd4;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [4*NREQ-1:0]  req_ctrl = '0;
   logic [16*NREQ-1:0] req_a = '0;
   logic [16*NREQ-1:0] req_b = '0;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready = '0;
   logic [15:0]        rsp_data;
   logic [3:0]         alu_ctrl;
   logic [15:0]        alu_a;
   logic [15:0]        alu_b;
   logic [15:0]        alu_y;
   logic               busy;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_res [NREQ];
   logic [19:0] sb_q [$];   // {owner index, expected result}

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctrl  (req_ctrl),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .alu_ctrl  (alu_ctrl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y),
      .busy      (busy)
   );

   // Registered ALU model, one-cycle latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) alu_y <= 16'h0;
      else begin
         case (alu_ctrl)
            OP_ADD:  alu_y <= alu_a + alu_b;
            OP_SUB:  alu_y <= alu_a - alu_b;
            OP_AND:  alu_y <= alu_a & alu_b;
            OP_XOR:  alu_y <= alu_a ^ alu_b;
            default: alu_y <= 16'h0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Issue watcher: record the expected response of every granted op.
   always @(negedge clk) begin
      if (resetn) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) sb_q.push_back({4'(i), exp_res[i]});
         end
      end
   end

   // Monitor: every accepted response must match the oldest outstanding op.
   always @(negedge clk) begin
      logic [19:0] e;
      int          own;
      if (resetn && ((rsp_valid & rsp_ready) != '0)) begin
         own = 0;
         for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) own = i;
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 64'(own), 64'hdead);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_owner", 64'(own), 64'(e[19:16]));
            chk("rsp_data", 64'(rsp_data), 64'(e[15:0]));
         end
      end
   end

   task automatic set_req(input int i, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] e);
      req_valid[i]        = 1'b1;
      req_ctrl[4*i +: 4]  = c;
      req_a[16*i +: 16]   = a;
      req_b[16*i +: 16]   = b;
      exp_res[i]          = e;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) exp_res[i] = 16'h0;

      // Reset: outputs must stay 0 even with every request asserted.
      req_valid = '1;
      rsp_ready = '1;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp", 64'({rsp_valid, rsp_data, busy}), 64'h0);
      chk("rst_alu", 64'({alu_ctrl, alu_a, alu_b}), 64'h0);
      req_valid = '0;
      next_cycle();
      resetn = 1'b1;

      // Single op.
      next_cycle();
      set_req(0, OP_ADD, 16'h0003, 16'h0004, 16'h0007);
      @(negedge clk);
      chk("single_grant", 64'(req_ready), 64'h1);
      chk("single_alu", 64'({alu_ctrl, alu_a, alu_b}), 64'h0_0003_0004);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("single_rsp", 64'({rsp_valid, rsp_data, busy}), 64'({4'b0001, 16'h0007, 1'b1}));
      next_cycle();
      @(negedge clk);
      chk("single_idle", 64'(busy), 64'h0);

      // Backpressure: owner holds off for 3 cycles, other requesters must wait.
      next_cycle();
      rsp_ready = '0;
      set_req(1, OP_SUB, 16'h0010, 16'h0001, 16'h000F);
      @(negedge clk);
      chk("bp_grant", 64'(req_ready), 64'h2);
      next_cycle();
      req_valid = '0;
      set_req(3, OP_ADD, 16'h1111, 16'h0001, 16'h1112);
      rsp_ready = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_hold_rsp", 64'({rsp_valid, rsp_data}), 64'({4'b0010, 16'h000F}));
         chk("bp_hold_ready", 64'(req_ready), 64'h0);
         if (c < 2) next_cycle();
      end
      next_cycle();
      req_valid = '0;
      rsp_ready = '1;
      @(negedge clk);
      chk("bp_accept", 64'({rsp_valid, rsp_data}), 64'({4'b0010, 16'h000F}));
      next_cycle();
      @(negedge clk);
      chk("bp_idle", 64'(busy), 64'h0);

      // Streaming: two ops from req 2 with no bubble.
      next_cycle();
      set_req(2, OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0);
      @(negedge clk);
      chk("stream_g0", 64'(req_ready), 64'h4);
      next_cycle();
      set_req(2, OP_AND, 16'hFFFF, 16'h1234, 16'h1234);
      @(negedge clk);
      chk("stream_g1", 64'({req_ready, rsp_valid, rsp_data}), 64'({4'b0100, 4'b0100, 16'h0FF0}));
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("stream_r1", 64'({rsp_valid, rsp_data}), 64'({4'b0100, 16'h1234}));

      // Contention from a fresh reset.
      next_cycle();
      resetn = 1'b0;
      sb_q.delete();
      next_cycle();
      resetn = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 16'(i * 256), 16'h0001, 16'(i * 256 + 1));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef ALU_ARB_RR_EN
         chk("contend_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
`else
         chk("contend_grant", 64'(req_ready), 64'h1);
`endif
         next_cycle();
      end
      req_valid = '0;
      repeat (2) next_cycle();

      // Reset in HOLD: everything clears at once, no stale response afterwards.
      rsp_ready = '0;
      set_req(1, OP_SUB, 16'h0020, 16'h0002, 16'h001E);
      next_cycle();
      req_valid = '0;
      next_cycle();
      @(negedge clk);
      chk("mid_hold", 64'({req_ready, rsp_valid, rsp_data}), 64'({4'b0000, 4'b0010, 16'h001E}));
      next_cycle();
      for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 16'(i * 16), 16'h0005, 16'(i * 16 + 5));
      rsp_ready = '1;
      resetn = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_all", {3'b0, req_ready, rsp_valid, rsp_data, alu_ctrl, alu_a, alu_b, busy}, 64'h0);
      next_cycle();
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_grant", 64'({req_ready, rsp_valid}), 64'({4'b0001, 4'b0000}));
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("post_rst_rsp", 64'({rsp_valid, rsp_data}), 64'({4'b0001, 16'h0005}));
      repeat (2) next_cycle();
      chk("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU (1-cycle latency, y registered on posedge) between NREQ requesters, e.g. decode/execute, address generation and a debug port.
- Arbitrates issue with a valid/ready handshake, tracks the in-flight op's owner, and returns the ALU result to that requester with response backpressure.
- Sits between the requesters and the alu instance; it drives the ALU's ctrl/a/b inputs and reads y.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, $clog2(NREQ), width of the owner index (derived; do not override).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester op request.
- req_ready  out  NREQ  per-requester grant; issue = req_valid[i] & req_ready[i].
- req_ctrl  in  4*NREQ  ALU opcode; requester i at [4i+3:4i].
- req_a  in  16*NREQ  operand a; requester i at [16i+15:16i].
- req_b  in  16*NREQ  operand b; requester i at [16i+15:16i].
- rsp_valid  out  NREQ  result valid for the owner only.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_data  out  16  result, shared bus; meaningful only when some rsp_valid bit is 1.
- alu_ctrl  out  4  to ALU ctrl.
- alu_a  out  16  to ALU a.
- alu_b  out  16  to ALU b.
- alu_y  in  16  from ALU y.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: state=IDLE; owner=0; hold=16'h0; rr pointer=NREQ-1, so req 0 wins first. All outputs read 0 while resetn is low.
- States:
  - IDLE: no result pending.
  - ISSUED: result appears on alu_y this cycle.
  - HOLD: result captured in hold register, awaiting accept.
- issue_ok = (IDLE) | ((ISSUED|HOLD) & rsp_ready[owner]).
- Arbitration (combinational):
  - When issue_ok, exactly one valid requester g is selected and req_ready = one-hot(g).
  - Otherwise req_ready = 0.
  - No req_valid set → req_ready = 0.
  - req_ready may depend on req_valid and rsp_ready. Requesters must not gate req_valid on req_ready.
- ALU drive (combinational):
  - On issue, alu_ctrl/alu_a/alu_b = requester g's fields.
  - Otherwise all three are 0. The ALU result for a non-issue cycle is ignored.
- Latency: an op issued in cycle T has its result on alu_y in T+1. rsp_valid[owner]=1 in T+1, with rsp_data=alu_y (state ISSUED).
- Transitions:
  - Issue in any state → ISSUED next cycle, owner<=g.
  - ISSUED, rsp_ready[owner]=0 → HOLD; hold<=alu_y.
  - ISSUED/HOLD, rsp_ready[owner]=1 and no new issue → IDLE.
  - HOLD, rsp_ready[owner]=0 → stay HOLD; rsp_data=hold and rsp_valid[owner] stays 1.
- Back-to-back: accept and new issue in the same cycle are allowed, giving a sustained throughput of 1 op/cycle.
- rsp_ready bits of non-owners are ignored.
- Operand stability: the requester's ctrl/a/b must be valid only in the issue cycle. There is no operand latching beyond that, because the ALU samples them at the edge ending T.
- Reset mid-operation: any in-flight op or held result is discarded with no response. The ALU's own reset clears y.
- busy = (state != IDLE).

Optional Feature:
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at rr+1 (mod NREQ).
  - rr <= g on each issue only; rr is unchanged when nothing issues.
- ALU_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - rr register is not built.
  - All other behaviour is identical.

Test Plan:
- Single op: req 0 issues ADD, a=16'h0003, b=16'h0004, rsp_ready[0]=1 → req_ready[0]=1 in T; rsp_valid[0]=1, rsp_data=16'h0007 in T+1; busy falls in T+2.
- Backpressure: req 1 issues SUB, a=16'h0010, b=16'h0001, rsp_ready[1] held low 3 cycles → HOLD; rsp_data=16'h000F stable, req_ready=0 throughout; accept releases and IDLE follows.
- Streaming: req 2 issues XOR 16'h00FF^16'h0F0F, then AND 16'hFFFF&16'h1234 back-to-back, rsp_ready=1 → results 16'h0FF0 then 16'h1234 on consecutive cycles, no bubble.
- Contention, with ALU_ARB_RR_EN: reqs 0–3 all valid for 8 issues → grant order 0,1,2,3,0,1,2,3.
  - Same test without the macro → all 8 grants go to req 0.
- Reset mid-op: assert resetn low in the HOLD state → all outputs 0 immediately. After release, the first grant goes to req 0 and no stale rsp_valid is produced.
